// File: rtl/ifm_window_loader_if.sv
`default_nettype none
// ============================================================================
// ifm_window_loader_if : pixel stream in, sliding window out
// Revision: 1.0
// ============================================================================
interface ifm_window_loader_if #(
  parameter int TAPS  = 32,
  parameter int PIX_W = 4
);
  logic                    s_valid;
  logic                    s_ready;
  logic [PIX_W-1:0]        s_data;
  logic                    s_last;
  logic                    win_valid;
  logic [TAPS*PIX_W-1:0]   win_data;
  logic                    win_first;
  logic                    win_last;
  logic                    frame_done;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, win_valid, win_data, win_first, win_last, frame_done
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, win_valid, win_data, win_first, win_last, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/ifm_window_loader.sv
`default_nettype none
// ============================================================================
// ifm_window_loader : builds TAPS-pixel sliding windows from a pixel stream
// Revision: 1.0
// ============================================================================
module ifm_window_loader #(
  parameter int TAPS   = 32,
  parameter int PIX_W  = 4,
  parameter int STRIDE = 1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  ifm_window_loader_if.slave bus
);
  localparam int              c_CNT_W  = $clog2(TAPS + 1);
  localparam int              c_WIN_W  = TAPS * PIX_W;
  localparam logic [c_CNT_W-1:0] c_TAPS   = c_CNT_W'(TAPS);
  localparam logic [c_CNT_W-1:0] c_STRIDE = c_CNT_W'(STRIDE);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_SLIDE = 2'd2,
    S_PAD   = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_fill_cnt;
  logic [c_CNT_W-1:0]   r_stride_cnt;
  logic [c_WIN_W-1:0]   r_store;
  logic [c_WIN_W-1:0]   r_win_data;
  logic                 r_win_valid;
  logic                 r_win_first;
  logic                 r_win_last;
  logic                 r_frame_done;
  logic                 r_s_ready;

  logic                 w_accept;
  logic [PIX_W-1:0]     w_pix;
  logic [c_WIN_W-1:0]   w_shifted;
  logic [c_CNT_W-1:0]   w_fill_inc;
  logic [c_CNT_W-1:0]   w_stride_inc;

  assign w_accept     = bus.s_valid & r_s_ready;
  assign w_pix        = (r_state == S_PAD) ? '0 : bus.s_data;
  assign w_fill_inc   = r_fill_cnt + c_ONE;
  assign w_stride_inc = r_stride_cnt + c_ONE;

  // Newest pixel enters at the top element; element 0 is always the oldest.
  generate
    if (TAPS == 1) begin : g_single_tap
      assign w_shifted = w_pix;
    end else begin : g_multi_tap
      assign w_shifted = {w_pix, r_store[c_WIN_W-1:PIX_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_fill_cnt   <= '0;
      r_stride_cnt <= '0;
      r_store      <= '0;
      r_win_data   <= '0;
      r_win_valid  <= 1'b0;
      r_win_first  <= 1'b0;
      r_win_last   <= 1'b0;
      r_frame_done <= 1'b0;
      r_s_ready    <= 1'b1;
    end else begin
      r_win_valid  <= 1'b0;
      r_win_first  <= 1'b0;
      r_win_last   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE, S_FILL: begin
          if (w_accept) begin
            r_store <= w_shifted;
            if (w_fill_inc == c_TAPS) begin
              r_win_valid  <= 1'b1;
              r_win_first  <= 1'b1;
              r_win_last   <= bus.s_last;
              r_win_data   <= w_shifted;
              r_stride_cnt <= '0;
              if (bus.s_last) begin
                r_frame_done <= 1'b1;
                r_fill_cnt   <= '0;
                r_state      <= S_IDLE;
              end else begin
                r_fill_cnt   <= w_fill_inc;
                r_state      <= S_SLIDE;
              end
            end else if (bus.s_last) begin
              r_fill_cnt <= w_fill_inc;
              r_s_ready  <= 1'b0;
              r_state    <= S_PAD;
            end else begin
              r_fill_cnt <= w_fill_inc;
              r_state    <= S_FILL;
            end
          end
        end
        S_SLIDE: begin
          if (w_accept) begin
            r_store <= w_shifted;
            if (w_stride_inc == c_STRIDE) begin
              r_win_valid  <= 1'b1;
              r_win_last   <= bus.s_last;
              r_win_data   <= w_shifted;
              r_stride_cnt <= '0;
            end else begin
              r_stride_cnt <= w_stride_inc;
            end
            // An incomplete trailing stride is dropped, never padded.
            if (bus.s_last) begin
              r_frame_done <= 1'b1;
              r_fill_cnt   <= '0;
              r_stride_cnt <= '0;
              r_state      <= S_IDLE;
            end
          end
        end
        S_PAD: begin
          r_store    <= w_shifted;
          r_fill_cnt <= w_fill_inc;
          if (w_fill_inc == c_TAPS) begin
            r_win_valid  <= 1'b1;
            r_win_first  <= 1'b1;
            r_win_last   <= 1'b1;
            r_win_data   <= w_shifted;
            r_frame_done <= 1'b1;
            r_fill_cnt   <= '0;
            r_stride_cnt <= '0;
            r_s_ready    <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ready    = r_s_ready;
  assign bus.win_valid  = r_win_valid;
  assign bus.win_data   = r_win_data;
  assign bus.win_first  = r_win_first;
  assign bus.win_last   = r_win_last;
  assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: doc/ifm_window_loader.md
IFM_WINDOW_LOADER -- requirements
Module: ifm_window_loader

Interface
REQ-001 Parameter TAPS, default 32, window length in pixels; SHALL match the convolution stage tap count.
REQ-002 Parameter PIX_W, default 4, pixel width in bits.
REQ-003 Parameter STRIDE, default 1, pixels between successive windows; legal range 1..TAPS.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_valid  input  1  upstream pixel valid.
REQ-007 s_ready  output  1  loader can accept a pixel.
REQ-008 s_data  input  PIX_W  pixel value, unsigned.
REQ-009 s_last  input  1  marks the final pixel of a frame; qualified by s_valid.
REQ-010 win_valid  output  1  one-cycle pulse, window ready; drives the convolution stage in_valid.
REQ-011 win_data  output  TAPS*PIX_W  window; element k at bits [k*PIX_W+PIX_W-1 : k*PIX_W]; element 0 is the oldest pixel and maps to In_IFM_1.
REQ-012 win_first  output  1  qualifies win_valid: first window of the frame.
REQ-013 win_last  output  1  qualifies win_valid: window completed by the frame's final pixel or by padding.
REQ-014 frame_done  output  1  one-cycle pulse, frame fully processed.

Function
REQ-015 A pixel SHALL be accepted only on an edge where s_valid and s_ready are both 1; s_valid=0 cycles SHALL change no state.
REQ-016 Window store: TAPS-entry shift register; each accepted pixel enters at element TAPS-1 and every element shifts down by one.
REQ-017 States: IDLE, FILL, SLIDE, PAD.
REQ-018 IDLE: fill_cnt=0, s_ready=1; the first accepted pixel moves to FILL, or to PAD if it carries s_last and TAPS>1.
REQ-019 FILL: fill_cnt counts accepted pixels; the pixel bringing fill_cnt to TAPS SHALL emit a window with win_first=1; next state SLIDE, stride_cnt cleared.
REQ-020 SLIDE: every STRIDE-th accepted pixel after the previous window SHALL emit a window with win_first=0.
REQ-021 Emission timing: win_valid, win_data, win_first and win_last SHALL be registered and valid in the cycle immediately after the accepting edge; win_valid is high for exactly one cycle per window.
REQ-022 win_data SHALL hold its value between windows; win_first and win_last SHALL be 0 whenever win_valid=0.
REQ-023 Consecutive-cycle windows (STRIDE=1, back-to-back pixels) SHALL be emitted on consecutive cycles without stalling s_ready.
REQ-024 s_last in SLIDE: if the pixel completes a window, that window has win_last=1; otherwise the pixels since the last window SHALL be discarded with no padding. Both cases pulse frame_done in the same cycle as the output registers and return to IDLE.
REQ-025 s_last in FILL with fill_cnt<TAPS after the pixel: go to PAD.
REQ-026 PAD: s_ready=0; one zero pixel shifts in per cycle until fill_cnt=TAPS. The window is then emitted with win_first=1 and win_last=1, frame_done pulses with it, and the next state is IDLE.
REQ-027 A single-pixel frame SHALL take TAPS-1 PAD cycles.
REQ-028 Counters: fill_cnt and stride_cnt SHALL be wide enough to hold TAPS without wrap and SHALL be cleared on entry to IDLE.
REQ-029 s_ready SHALL be 1 in IDLE, FILL and SLIDE, and 0 only in PAD.
REQ-030 Output timing is compatible with the convolution stage, which produces Out_OFM with out_valid two cycles after in_valid.

Reset
REQ-031 On rst_n low, the block SHALL go to IDLE and clear all counters.
REQ-032 Reset values: win_valid=0, win_first=0, win_last=0, frame_done=0, win_data=0, s_ready=1 after release.
REQ-033 Reset asserted mid-frame SHALL discard the partial window; the next frame starts with fill_cnt=0.

Verification
REQ-034 Reset: rst_n low for 3 cycles, then released -> all outputs 0, s_ready=1.
REQ-035 STRIDE=1, 32-pixel frame, pixel i = i mod 16, s_last on pixel 31 -> one win_valid with win_first=1 and win_last=1; element 0 = 0 and element 31 = 15; frame_done in the same cycle.
REQ-036 STRIDE=1, 34 back-to-back pixels (value = index mod 16) -> win_valid on 3 consecutive cycles; third window element 0 = 2 and element 31 = 1 (pixel 33); win_first on the first window only, win_last on the third only.
REQ-037 5-pixel frame of 0xF with s_last -> s_ready low for 27 cycles; window elements 0..4 = 0xF and 5..31 = 0; win_first=win_last=1; frame_done; s_ready returns to 1.
REQ-038 STRIDE=4, 37-pixel frame with random s_valid gaps -> windows only at pixels 32 and 36; pixel 37 discarded; frame_done with win_valid=0; win_last never asserted.
REQ-039 rst_n pulsed after 10 pixels, then a 32-pixel frame of 0x3 -> one window with all elements 0x3; no window is produced from the pre-reset pixels.
